// File: rtl/multicycle_control_v2.sv
// Multicycle RV32I control unit with a variable-latency memory handshake.
// It decodes R, I-ALU, load, store, branch, JAL and LUI instructions.
// Illegal opcodes and gated-off features either halt the FSM or skip the instruction.
//
// Ports:
//   clk, reset                  rising-edge clock; synchronous active-low reset
//   opcode, funct3, funct7      instruction register fields
//   zero_flag, lt_flag,         ALU compare flags used to resolve branches
//   ltu_flag
//   mem_ready                   memory completes the current access this cycle
//   mem_req, mem_write          memory request and store strobe
//   reg_write, ir_write,        register file, IR and PC write enables
//   pc_write
//   instruction_or_data         memory address select (0 = PC, 1 = ALUOut)
//   result_src, alu_src_a,      datapath multiplexer selects
//   alu_src_b
//   alu_control                 ALU operation
//   current_state               current state encoding, for debug
//   illegal                     high while in the ILLEGAL state
//
// The outputs are a combinational decode of the state register.
// ir_write and pc_write follow mem_ready during FETCH.
module multicycle_control_v2 #(
  parameter bit BRANCH_FULL  = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter bit ENABLE_JAL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       instruction_or_data,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [3:0] current_state,
  output logic       illegal
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC_R    = 4'd6;
  localparam logic [STATE_W-1:0] S_EXEC_I    = 4'd7;
  localparam logic [STATE_W-1:0] S_ALU_WB    = 4'd8;
  localparam logic [STATE_W-1:0] S_BRANCH    = 4'd9;
  localparam logic [STATE_W-1:0] S_JAL       = 4'd10;
  localparam logic [STATE_W-1:0] S_LUI       = 4'd11;
  localparam logic [STATE_W-1:0] S_ILLEGAL   = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;

  // funct3 to ALU op; alt selects sub (000) or sra (101).
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch taken condition. The illegal funct3 values 010 and 011 are never taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  assign current_state = state;

  // Next-state and output decode.
  always_comb begin
    state_next          = S_FETCH;
    mem_req             = 1'b0;
    mem_write           = 1'b0;
    reg_write           = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = 2'b00;
    alu_src_a           = 2'b00;
    alu_src_b           = 2'b00;
    alu_control         = ALU_ADD;
    illegal             = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch/JAL target into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = (!BRANCH_FULL && (funct3[2:1] != 2'b00))
                                          ? S_ILLEGAL : S_BRANCH;
          OP_JAL:            state_next = ENABLE_JAL ? S_JAL : S_ILLEGAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req             = 1'b1;
        instruction_or_data = 1'b1;
        state_next          = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req             = 1'b1;
        mem_write           = 1'b1;
        instruction_or_data = 1'b1;
        state_next          = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, funct7[5]);
        state_next  = ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))
                      ? S_ALU_WB : S_ILLEGAL;
      end
      S_EXEC_I: begin
        // Only srai honours funct7[5]; addi never becomes sub.
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = branch_taken(funct3, zero_flag, lt_flag, ltu_flag);
        state_next  = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4 for the link.
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        state_next = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_PASSB;
        state_next  = S_ALU_WB;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // During reset, suppress every side effect so an in-flight access is abandoned.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Bench for multicycle_control_v2. It runs two instances side by side.
// dut_a uses the default parameters.
// dut_b sets BRANCH_FULL=0, ILLEGAL_HALT=0 and ENABLE_JAL=0.
// An instruction-level model builds the remaining step sequence of each instruction when it reaches decode.
// The model supplies the expected outputs for every cycle of both instances.
module tb_multicycle_control_v2;

  localparam logic [2:0] K_NONE = 3'd0, K_FETCH = 3'd1, K_DECODE = 3'd2, K_EXECR = 3'd3,
                         K_EXECI = 3'd4, K_BRANCH = 3'd5, K_ILL = 3'd6;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       iod;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic       ill;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic       waits;
    logic [2:0] kind;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero_flag, lt_flag, ltu_flag, mem_ready;
  logic [6:0] opcode_a, funct7_a, opcode_b, funct7_b;
  logic [2:0] funct3_a, funct3_b;

  logic       mreq_a, mw_a, rw_a, irw_a, pcw_a, iod_a, ill_a;
  logic       mreq_b, mw_b, rw_b, irw_b, pcw_b, iod_b, ill_b;
  logic [1:0] rs_a, as_a, bs_a, rs_b, as_b, bs_b;
  logic [3:0] alu_a, cs_a, alu_b, cs_b;

  multicycle_control_v2 dut_a (
    .clk(clk), .reset(reset), .opcode(opcode_a), .funct3(funct3_a), .funct7(funct7_a),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .mem_req(mreq_a), .mem_write(mw_a), .reg_write(rw_a), .ir_write(irw_a),
    .pc_write(pcw_a), .instruction_or_data(iod_a), .result_src(rs_a), .alu_src_a(as_a),
    .alu_src_b(bs_a), .alu_control(alu_a), .current_state(cs_a), .illegal(ill_a)
  );

  multicycle_control_v2 #(.BRANCH_FULL(1'b0), .ILLEGAL_HALT(1'b0), .ENABLE_JAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode_b), .funct3(funct3_b), .funct7(funct7_b),
    .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .mem_ready(mem_ready),
    .mem_req(mreq_b), .mem_write(mw_b), .reg_write(rw_b), .ir_write(irw_b),
    .pc_write(pcw_b), .instruction_or_data(iod_b), .result_src(rs_b), .alu_src_a(as_b),
    .alu_src_b(bs_b), .alu_control(alu_b), .current_state(cs_b), .illegal(ill_b)
  );

  outs_t live_a, live_b, oa, ob;
  assign live_a = {cs_a, mreq_a, mw_a, rw_a, irw_a, pcw_a, iod_a, rs_a, as_a, bs_a, alu_a, ill_a};
  assign live_b = {cs_b, mreq_b, mw_b, rw_b, irw_b, pcw_b, iod_b, rs_b, as_b, bs_b, alu_b, ill_b};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  step_t q [2][8];
  int    qn [2];

  logic [6:0] d_op, d_f7;
  logic [2:0] d_f3;
  logic [6:0] r_op [2];
  logic [6:0] r_f7 [2];
  logic [2:0] r_f3 [2];

  function automatic step_t mk(input logic [3:0] st, input logic req, input logic wr,
                               input logic iod, input logic [1:0] rs, input logic [1:0] a,
                               input logic [1:0] b, input logic [3:0] alu, input logic rw,
                               input logic pcw, input logic waits, input logic [2:0] kind);
    step_t s;
    s.o = '{st: st, mem_req: req, mem_write: wr, reg_write: rw, ir_write: 1'b0,
            pc_write: pcw, iod: iod, rs: rs, a: a, b: b, alu: alu, ill: 1'b0};
    s.waits = waits;
    s.kind  = kind;
    return s;
  endfunction

  // Steps of each instruction class.
  function automatic step_t s_fetch();  return mk(4'd0, 1,0,0, 2'd2, 2'd0, 2'd2, 4'd0, 0,0, 1, K_FETCH);  endfunction
  function automatic step_t s_decode(); return mk(4'd1, 0,0,0, 2'd0, 2'd1, 2'd1, 4'd0, 0,0, 0, K_DECODE); endfunction
  function automatic step_t s_addr();   return mk(4'd2, 0,0,0, 2'd0, 2'd2, 2'd1, 4'd0, 0,0, 0, K_NONE);   endfunction
  function automatic step_t s_read();   return mk(4'd3, 1,0,1, 2'd0, 2'd0, 2'd0, 4'd0, 0,0, 1, K_NONE);   endfunction
  function automatic step_t s_mwb();    return mk(4'd4, 0,0,0, 2'd1, 2'd0, 2'd0, 4'd0, 1,0, 0, K_NONE);   endfunction
  function automatic step_t s_write();  return mk(4'd5, 1,1,1, 2'd0, 2'd0, 2'd0, 4'd0, 0,0, 1, K_NONE);   endfunction
  function automatic step_t s_execr();  return mk(4'd6, 0,0,0, 2'd0, 2'd2, 2'd0, 4'd0, 0,0, 0, K_EXECR);  endfunction
  function automatic step_t s_execi();  return mk(4'd7, 0,0,0, 2'd0, 2'd2, 2'd1, 4'd0, 0,0, 0, K_EXECI);  endfunction
  function automatic step_t s_aluwb();  return mk(4'd8, 0,0,0, 2'd0, 2'd0, 2'd0, 4'd0, 1,0, 0, K_NONE);   endfunction
  function automatic step_t s_branch(); return mk(4'd9, 0,0,0, 2'd0, 2'd2, 2'd0, 4'd1, 0,0, 0, K_BRANCH); endfunction
  function automatic step_t s_jal();    return mk(4'd10,0,0,0, 2'd0, 2'd1, 2'd2, 4'd0, 0,1, 0, K_NONE);   endfunction
  function automatic step_t s_lui();    return mk(4'd11,0,0,0, 2'd0, 2'd0, 2'd1, 4'd10,0,0, 0, K_NONE);   endfunction
  function automatic step_t s_ill();    return mk(4'd15,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0, 0,0, 0, K_ILL);    endfunction

  // ALU op implied by funct3, with the alternate encoding for sub/sra.
  function automatic logic [3:0] ralu(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [0:7];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd9;
    return tbl[f3];
  endfunction

  task automatic push(input int m, input step_t s);
    if (qn[m] < 8) begin
      q[m][qn[m]] = s;
      qn[m]++;
    end
  endtask

  task automatic pop(input int m);
    for (int i = 0; i < 7; i++) q[m][i] = q[m][i+1];
    if (qn[m] > 0) qn[m]--;
  endtask

  task automatic restart(input int m);
    qn[m] = 0;
    push(m, s_fetch());
    push(m, s_decode());
  endtask

  // Queue the remaining steps of an instruction once its opcode is decoded.
  task automatic push_class(input int m, input bit bf, input bit ej,
                            input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: begin push(m, s_addr()); push(m, s_read()); push(m, s_mwb()); end
      7'b0100011: begin push(m, s_addr()); push(m, s_write()); end
      7'b0110011: begin push(m, s_execr()); push(m, s_aluwb()); end
      7'b0010011: begin push(m, s_execi()); push(m, s_aluwb()); end
      7'b1100011: if (!bf && f3 > 3'd1) push(m, s_ill()); else push(m, s_branch());
      7'b1101111: if (ej) begin push(m, s_jal()); push(m, s_aluwb()); end else push(m, s_ill());
      7'b0110111: begin push(m, s_lui()); push(m, s_aluwb()); end
      default:    push(m, s_ill());
    endcase
  endtask

  // Produce this cycle's expected outputs, then advance the model across the clock edge.
  task automatic model(input int m, input bit bf, input bit ih, input bit ej,
                       input logic rst, input logic rdy, input logic z, input logic lt,
                       input logic ltu, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, output outs_t e);
    step_t s;
    logic  bad, cond;
    if (qn[m] == 0) restart(m);
    s   = q[m][0];
    e   = s.o;
    bad = 1'b0;
    case (s.kind)
      K_FETCH: begin e.ir_write = rdy; e.pc_write = rdy; end
      K_EXECR: begin e.alu = ralu(f3, f7[5]); bad = !(f7 == 7'h00 || f7 == 7'h20); end
      K_EXECI: e.alu = ralu(f3, (f3 == 3'd5) && f7[5]);
      K_BRANCH: begin
        bad  = (f3 == 3'd2) || (f3 == 3'd3);
        cond = f3[2] ? (f3[1] ? ltu : lt) : z;
        e.pc_write = !bad && (cond ^ f3[0]);
      end
      K_ILL: e.ill = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      e.mem_req = 0; e.mem_write = 0; e.reg_write = 0; e.ir_write = 0; e.pc_write = 0; e.ill = 0;
      restart(m);
    end else if (!(s.waits && !rdy)) begin
      pop(m);
      if (s.kind == K_DECODE) push_class(m, bf, ej, op, f3);
      if (bad) begin qn[m] = 0; push(m, s_ill()); end
      if (s.kind == K_ILL && ih) push(m, s_ill());
      if (qn[m] == 0) restart(m);
    end
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic z, input logic lt,
                       input logic ltu, input logic [6:0] opa, input logic [2:0] f3a,
                       input logic [6:0] f7a, input logic [6:0] opb, input logic [2:0] f3b,
                       input logic [6:0] f7b);
    outs_t ea, eb;
    @(negedge clk);
    reset = rst; mem_ready = rdy; zero_flag = z; lt_flag = lt; ltu_flag = ltu;
    opcode_a = opa; funct3_a = f3a; funct7_a = f7a;
    opcode_b = opb; funct3_b = f3b; funct7_b = f7b;
    #1;
    cyc++;
    model(0, 1'b1, 1'b1, 1'b1, rst, rdy, z, lt, ltu, opa, f3a, f7a, ea);
    model(1, 1'b0, 1'b0, 1'b0, rst, rdy, z, lt, ltu, opb, f3b, f7b, eb);
    oa = live_a;
    ob = live_b;
    checks++;
    if (live_a !== ea) begin
      failures++;
      $display("FAIL model_a cycle %0d: got %h expected %h", cyc, live_a, ea);
    end
    checks++;
    if (live_b !== eb) begin
      failures++;
      $display("FAIL model_b cycle %0d: got %h expected %h", cyc, live_b, eb);
    end
  endtask

  task automatic dcyc(input logic rst, input logic rdy, input logic z, input logic lt,
                      input logic ltu);
    cycle(rst, rdy, z, lt, ltu, d_op, d_f3, d_f7, d_op, d_f3, d_f7);
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [0:8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0000000, 7'b1110011};
    return ops[$urandom_range(0, 8)];
  endfunction

  initial begin
    reset = 1'b0; mem_ready = 1'b0; zero_flag = 1'b0; lt_flag = 1'b0; ltu_flag = 1'b0;
    opcode_a = '0; funct3_a = '0; funct7_a = '0;
    opcode_b = '0; funct3_b = '0; funct7_b = '0;
    restart(0);
    restart(1);

    // Reset held for two edges with mem_ready high.
    d_op = 7'b0010011; d_f3 = 3'd0; d_f7 = 7'd0;
    for (int k = 0; k < 2; k++) begin
      dcyc(0, 1, 0, 0, 0);
      lit("rst_state", 32'(oa.st), 0);
      lit("rst_enables", 32'({oa.mem_req, oa.mem_write, oa.reg_write, oa.ir_write, oa.pc_write, oa.ill}), 0);
    end
    dcyc(1, 1, 0, 0, 0);
    lit("first_fetch_ir_write", 32'(oa.ir_write), 1);
    lit("first_fetch_pc_write", 32'(oa.pc_write), 1);
    repeat (3) dcyc(1, 1, 0, 0, 0);

    // addi x3,x1,0 with three fetch wait states.
    for (int k = 0; k < 4; k++) begin
      dcyc(1, k == 3, 0, 0, 0);
      lit("addi_fetch_state", 32'(oa.st), 0);
      lit("addi_fetch_pc_write", 32'(oa.pc_write), 32'(k == 3));
    end
    dcyc(1, 1, 0, 0, 0); lit("addi_decode", 32'(oa.st), 1);
    dcyc(1, 1, 0, 0, 0); lit("addi_exec_i", 32'(oa.st), 7); lit("addi_alu", 32'(oa.alu), 0);
    dcyc(1, 1, 0, 0, 0); lit("addi_alu_wb", 32'(oa.st), 8); lit("addi_reg_write", 32'(oa.reg_write), 1);

    // beq taken, then bltu not taken.
    d_op = 7'b1100011; d_f3 = 3'b000;
    dcyc(1, 1, 0, 0, 0); dcyc(1, 1, 0, 0, 0);
    dcyc(1, 1, 1, 0, 0);
    lit("beq_state", 32'(oa.st), 9); lit("beq_pc_write", 32'(oa.pc_write), 1);
    lit("beq_pc_write_b", 32'(ob.pc_write), 1);
    d_f3 = 3'b110;
    dcyc(1, 1, 0, 0, 0); dcyc(1, 1, 0, 0, 0);
    dcyc(1, 1, 0, 0, 0);
    lit("bltu_state", 32'(oa.st), 9); lit("bltu_pc_write", 32'(oa.pc_write), 0);
    lit("bltu_gated_b", 32'(ob.st), 15);

    // lw then sw with two data wait states.
    d_op = 7'b0000011; d_f3 = 3'b010;
    dcyc(1, 1, 0, 0, 0); lit("lw_fetch_a", 32'(oa.st), 0); lit("lw_fetch_b", 32'(ob.st), 0);
    dcyc(1, 1, 0, 0, 0);
    dcyc(1, 1, 0, 0, 0); lit("lw_mem_addr", 32'(oa.st), 2);
    for (int k = 0; k < 3; k++) begin
      dcyc(1, k == 2, 0, 0, 0);
      lit("lw_read_state", 32'(oa.st), 3); lit("lw_iod", 32'(oa.iod), 1);
      lit("lw_mem_write", 32'(oa.mem_write), 0);
    end
    dcyc(1, 1, 0, 0, 0);
    lit("lw_wb_state", 32'(oa.st), 4); lit("lw_wb_reg_write", 32'(oa.reg_write), 1);
    lit("lw_wb_result_src", 32'(oa.rs), 1);
    d_op = 7'b0100011;
    repeat (3) dcyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      dcyc(1, k == 2, 0, 0, 0);
      lit("sw_write_state", 32'(oa.st), 5); lit("sw_mem_write", 32'(oa.mem_write), 1);
      lit("sw_iod", 32'(oa.iod), 1);
    end

    // Illegal opcode: dut_a parks, dut_b skips.
    d_op = 7'b0000000; d_f3 = 3'd0;
    dcyc(1, 1, 0, 0, 0); lit("sw_done_fetch", 32'(oa.st), 0);
    dcyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      dcyc(1, 1, 0, 0, 0);
      lit("halt_state", 32'(oa.st), 15); lit("halt_illegal", 32'(oa.ill), 1);
      if (k == 0) lit("skip_illegal_b", 32'(ob.ill), 1);
      if (k == 1) lit("skip_fetch_b", 32'(ob.st), 0);
    end
    dcyc(0, 1, 0, 0, 0);

    // blt and jal on the gated instance.
    d_op = 7'b1100011; d_f3 = 3'b100;
    dcyc(1, 1, 0, 0, 0); lit("halt_reset_state", 32'(oa.st), 0);
    dcyc(1, 1, 0, 0, 0);
    dcyc(1, 1, 0, 1, 0);
    lit("blt_taken_a", 32'(oa.pc_write), 1); lit("blt_gated_b", 32'(ob.st), 15);
    lit("blt_no_pcw_b", 32'(ob.pc_write), 0);
    d_op = 7'b1101111;
    dcyc(1, 1, 0, 0, 0); dcyc(1, 1, 0, 0, 0);
    dcyc(1, 1, 0, 0, 0);
    lit("jal_state_a", 32'(oa.st), 10); lit("jal_pcw_a", 32'(oa.pc_write), 1);
    lit("jal_gated_b", 32'(ob.st), 15); lit("jal_no_pcw_b", 32'(ob.pc_write), 0);

    // Random instruction streams, wait states and resets.
    for (int m = 0; m < 2; m++) begin
      r_op[m] = 7'b0110011; r_f3[m] = 3'd0; r_f7[m] = 7'd0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (qn[m] > 0 && q[m][0].kind == K_FETCH) begin
          r_op[m] = rand_op();
          r_f3[m] = 3'($urandom_range(0, 7));
          case ($urandom_range(0, 9))
            0:       r_f7[m] = 7'($urandom_range(0, 127));
            1, 2, 3: r_f7[m] = 7'h20;
            default: r_f7[m] = 7'h00;
          endcase
        end
      end
      cycle($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            r_op[0], r_f3[0], r_f7[0], r_op[1], r_f3[1], r_f7[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
